// File: rtl/add_rm_hdr_sf.sv
// MAC shim: rx buffers whole frames and prepends a length/port header; tx strips leading header words.
// Latency: rx header 2 cycles after the final word is accepted, tx 1 cycle; backpressure via *_rdy, with overflowing rx frames dropped.
module add_rm_hdr_sf #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int IOQ_STAGE_NUM = 'hff,
    parameter int PORT_NUMBER   = 0,
    parameter int BUF_ADDR_BITS = 9,
    parameter int LEN_FIFO_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_in_data,
    input  logic [CTRL_WIDTH-1:0] rx_in_ctrl,
    input  logic                  rx_in_wr,
    output logic                  rx_in_rdy,
    output logic [DATA_WIDTH-1:0] rx_out_data,
    output logic [CTRL_WIDTH-1:0] rx_out_ctrl,
    output logic                  rx_out_wr,
    input  logic                  rx_out_rdy,
    input  logic [DATA_WIDTH-1:0] tx_in_data,
    input  logic [CTRL_WIDTH-1:0] tx_in_ctrl,
    input  logic                  tx_in_wr,
    output logic                  tx_in_rdy,
    output logic [DATA_WIDTH-1:0] tx_out_data,
    output logic [CTRL_WIDTH-1:0] tx_out_ctrl,
    output logic                  tx_out_wr,
    input  logic                  tx_out_rdy,
    output logic [31:0]           rx_pkt_cnt,
    output logic [31:0]           rx_drop_cnt
);

    localparam int DEPTH  = 1 << BUF_ADDR_BITS;
    localparam int LDEPTH = 1 << LEN_FIFO_BITS;
    localparam int WW     = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [BUF_ADDR_BITS:0] BONE     = 1;
    localparam logic [BUF_ADDR_BITS:0] BFULL    = {1'b1, {BUF_ADDR_BITS{1'b0}}};
    localparam logic [LEN_FIFO_BITS:0] LONE     = 1;
    localparam logic [LEN_FIFO_BITS:0] LFULL    = {1'b1, {LEN_FIFO_BITS{1'b0}}};
    localparam logic [CTRL_WIDTH-1:0]  HDR_CTRL = CTRL_WIDTH'(IOQ_STAGE_NUM);

    typedef enum logic {RX_IDLE, RX_BODY} rx_state_e;
    typedef enum logic {TX_SKIP, TX_PASS} tx_state_e;

    logic [WW-1:0] buf_mem [DEPTH];
    logic [31:0]   len_mem [LDEPTH];

    logic                   rst_done_q;
    logic                   rx_acc, rx_last, buf_full, mem_we, len_push, len_pop, len_full, len_empty;
    logic                   drop_q, drop_d, drop_inc, pkt_inc;
    logic [BUF_ADDR_BITS:0] wr_ptr_q, wr_ptr_d, commit_q, commit_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]            word_cnt_q, word_cnt_d, byte_cnt_q, byte_cnt_d, word_sum, byte_sum;
    logic [16:0]            word_inc, byte_inc, nbytes;
    logic [LEN_FIFO_BITS:0] len_wp_q, len_rp_q;
    logic [31:0]            len_head;
    logic [63:0]            hdr64;
    logic [DATA_WIDTH+63:0] hdr_ext;
    rx_state_e              rx_state_q, rx_state_d;
    logic [15:0]            rem_q, rem_d;
    logic                   rx_vld_q, rx_vld_d, rx_adv;
    logic [DATA_WIDTH-1:0]  rx_dat_q, rx_dat_d;
    logic [CTRL_WIDTH-1:0]  rx_ctl_q, rx_ctl_d;
    logic [31:0]            pkt_cnt_q, drop_cnt_q;
    tx_state_e              tx_state_q, tx_state_d;
    logic                   tx_acc, tx_fwd, tx_vld_q;
    logic [DATA_WIDTH-1:0]  tx_dat_q;
    logic [CTRL_WIDTH-1:0]  tx_ctl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_done_q <= 1'b0;
        else        rst_done_q <= 1'b1;
    end

    assign rx_last   = |rx_in_ctrl;
    assign rx_in_rdy = rst_done_q & (drop_q | ~len_full);
    assign rx_acc    = rx_in_wr & rx_in_rdy;
    assign buf_full  = (wr_ptr_q ^ rd_ptr_q) == BFULL;

    // Final-word ctrl bit k means CTRL_WIDTH-k valid bytes; other words are full.
    always_comb begin
        nbytes = 17'(CTRL_WIDTH);
        for (int k = 0; k < CTRL_WIDTH; k++)
            if (rx_in_ctrl[k]) nbytes = 17'(CTRL_WIDTH - k);
    end

    assign word_inc = {1'b0, word_cnt_q} + 17'd1;
    assign byte_inc = {1'b0, byte_cnt_q} + nbytes;
    assign word_sum = word_inc[16] ? 16'hffff : word_inc[15:0];
    assign byte_sum = byte_inc[16] ? 16'hffff : byte_inc[15:0];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        commit_d   = commit_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        drop_d     = drop_q;
        mem_we     = 1'b0;
        len_push   = 1'b0;
        drop_inc   = 1'b0;
        if (rx_acc) begin
            if (drop_q) begin
                if (rx_last) begin
                    drop_d   = 1'b0;
                    wr_ptr_d = commit_q;
                    drop_inc = 1'b1;
                end
            end else if (buf_full) begin
                word_cnt_d = '0;
                byte_cnt_d = '0;
                if (rx_last) begin
                    wr_ptr_d = commit_q;
                    drop_inc = 1'b1;
                end else begin
                    drop_d = 1'b1;
                end
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + BONE;
                if (rx_last) begin
                    len_push   = 1'b1;
                    commit_d   = wr_ptr_q + BONE;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                end else begin
                    word_cnt_d = word_sum;
                    byte_cnt_d = byte_sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)   buf_mem[wr_ptr_q[BUF_ADDR_BITS-1:0]] <= {rx_in_ctrl, rx_in_data};
        if (len_push) len_mem[len_wp_q[LEN_FIFO_BITS-1:0]] <= {word_sum, byte_sum};
    end

    assign len_full  = (len_wp_q ^ len_rp_q) == LFULL;
    assign len_empty = len_wp_q == len_rp_q;
    assign len_head  = len_mem[len_rp_q[LEN_FIFO_BITS-1:0]];
    assign hdr64     = {len_head[31:16], 16'(2 * PORT_NUMBER), 16'h0000, len_head[15:0]};
    assign hdr_ext   = {{DATA_WIDTH{1'b0}}, hdr64};

    assign rx_adv      = ~rx_vld_q | rx_out_rdy;
    assign rx_out_wr   = rx_vld_q & rx_out_rdy;
    assign rx_out_data = rx_dat_q;
    assign rx_out_ctrl = rx_ctl_q;

    // The header is launched straight from idle so it lands two cycles after the final write.
    always_comb begin
        rx_state_d = rx_state_q;
        rem_d      = rem_q;
        rd_ptr_d   = rd_ptr_q;
        rx_vld_d   = rx_vld_q & ~rx_out_rdy;
        rx_dat_d   = rx_dat_q;
        rx_ctl_d   = rx_ctl_q;
        len_pop    = 1'b0;
        pkt_inc    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!len_empty && rx_adv) begin
                    rx_dat_d   = hdr_ext[DATA_WIDTH-1:0];
                    rx_ctl_d   = HDR_CTRL;
                    rx_vld_d   = 1'b1;
                    rem_d      = len_head[31:16];
                    rx_state_d = RX_BODY;
                end
            end
            RX_BODY: begin
                if (rx_adv) begin
                    {rx_ctl_d, rx_dat_d} = buf_mem[rd_ptr_q[BUF_ADDR_BITS-1:0]];
                    rx_vld_d = 1'b1;
                    rd_ptr_d = rd_ptr_q + BONE;
                    rem_d    = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        len_pop    = 1'b1;
                        pkt_inc    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            commit_q   <= '0;
            rd_ptr_q   <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            drop_q     <= 1'b0;
            len_wp_q   <= '0;
            len_rp_q   <= '0;
            rx_state_q <= RX_IDLE;
            rem_q      <= '0;
            rx_vld_q   <= 1'b0;
            rx_dat_q   <= '0;
            rx_ctl_q   <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            commit_q   <= commit_d;
            rd_ptr_q   <= rd_ptr_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            drop_q     <= drop_d;
            if (len_push) len_wp_q <= len_wp_q + LONE;
            if (len_pop)  len_rp_q <= len_rp_q + LONE;
            rx_state_q <= rx_state_d;
            rem_q      <= rem_d;
            rx_vld_q   <= rx_vld_d;
            rx_dat_q   <= rx_dat_d;
            rx_ctl_q   <= rx_ctl_d;
            if (pkt_inc)  pkt_cnt_q  <= pkt_cnt_q + 32'd1;
            if (drop_inc) drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign rx_pkt_cnt  = pkt_cnt_q;
    assign rx_drop_cnt = drop_cnt_q;

    assign tx_in_rdy   = rst_done_q & (tx_out_rdy | ~tx_vld_q);
    assign tx_acc      = tx_in_wr & tx_in_rdy;
    assign tx_fwd      = tx_acc & ((tx_state_q == TX_PASS) | (tx_in_ctrl == '0));
    assign tx_out_wr   = tx_vld_q & tx_out_rdy;
    assign tx_out_data = tx_dat_q;
    assign tx_out_ctrl = tx_ctl_q;

    always_comb begin
        tx_state_d = tx_state_q;
        if (tx_acc) begin
            case (tx_state_q)
                TX_SKIP: if (tx_in_ctrl == '0) tx_state_d = TX_PASS;
                TX_PASS: if (tx_in_ctrl != '0) tx_state_d = TX_SKIP;
                default: tx_state_d = TX_SKIP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_SKIP;
            tx_vld_q   <= 1'b0;
            tx_dat_q   <= '0;
            tx_ctl_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_vld_q   <= tx_fwd | (tx_vld_q & ~tx_out_rdy);
            if (tx_fwd) begin
                tx_dat_q <= tx_in_data;
                tx_ctl_q <= tx_in_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_add_rm_hdr_sf.sv
// Bench for add_rm_hdr_sf: table of frames with explicit headers, corner sequences, then random traffic vs a queue model.
module tb_add_rm_hdr_sf;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] rx_in_data = '0, rx_out_data, tx_in_data = '0, tx_out_data;
    logic [7:0]  rx_in_ctrl = '0, rx_out_ctrl, tx_in_ctrl = '0, tx_out_ctrl;
    logic        rx_in_wr = 1'b0, rx_in_rdy, rx_out_wr, rx_out_rdy = 1'b1;
    logic        tx_in_wr = 1'b0, tx_in_rdy, tx_out_wr, tx_out_rdy = 1'b1;
    logic [31:0] rx_pkt_cnt, rx_drop_cnt;

    always #5 clk = ~clk;

    add_rm_hdr_sf #(
        .DATA_WIDTH(64), .CTRL_WIDTH(8), .IOQ_STAGE_NUM('hff),
        .PORT_NUMBER(3), .BUF_ADDR_BITS(4), .LEN_FIFO_BITS(2)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_in_data(rx_in_data), .rx_in_ctrl(rx_in_ctrl), .rx_in_wr(rx_in_wr), .rx_in_rdy(rx_in_rdy),
        .rx_out_data(rx_out_data), .rx_out_ctrl(rx_out_ctrl), .rx_out_wr(rx_out_wr), .rx_out_rdy(rx_out_rdy),
        .tx_in_data(tx_in_data), .tx_in_ctrl(tx_in_ctrl), .tx_in_wr(tx_in_wr), .tx_in_rdy(tx_in_rdy),
        .tx_out_data(tx_out_data), .tx_out_ctrl(tx_out_ctrl), .tx_out_wr(tx_out_wr), .tx_out_rdy(tx_out_rdy),
        .rx_pkt_cnt(rx_pkt_cnt), .rx_drop_cnt(rx_drop_cnt)
    );

    typedef struct packed {logic h; logic [7:0] c; logic [63:0] d;} wd_t;
    typedef struct {int n; logic [7:0] lc; logic [63:0] hdr;} vec_t;

    wd_t rx_src[$], rx_exp[$], tx_src[$], tx_exp[$];
    int  checks = 0, passed = 0, cyc_n = 0, rx_pct = 100, tx_pct = 100, outstanding = 0;
    int  rx_fin_cyc = 0, rx_hdr_cyc = 0, rx_out_cyc = 0, tx_in_cyc = 0, tx_out_cyc = 0;
    logic [31:0] exp_pkt = 0, exp_drop = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One clock: randomise sink readiness, offer source words, record output transfers.
    task automatic cyc();
        wd_t w;
        @(negedge clk);
        cyc_n++;
        rx_out_rdy = ($urandom_range(0, 99) < rx_pct);
        tx_out_rdy = ($urandom_range(0, 99) < tx_pct);
        #1;
        rx_in_wr = 1'b0;
        tx_in_wr = 1'b0;
        if (rx_src.size() != 0 && rx_in_rdy) begin
            w = rx_src.pop_front();
            rx_in_data = w.d; rx_in_ctrl = w.c; rx_in_wr = 1'b1;
            if (w.c != 0) rx_fin_cyc = cyc_n;
        end
        if (tx_src.size() != 0 && tx_in_rdy) begin
            w = tx_src.pop_front();
            tx_in_data = w.d; tx_in_ctrl = w.c; tx_in_wr = 1'b1;
            tx_in_cyc = cyc_n;
        end
        #1;
        if (rx_out_wr) begin
            if (rx_exp.size() == 0) begin
                checks++;
                $display("FAIL rx_extra_word: got %h expected no word", {rx_out_ctrl, rx_out_data});
            end else begin
                w = rx_exp.pop_front();
                if (w.h) rx_hdr_cyc = cyc_n;
                else outstanding--;
                rx_out_cyc = cyc_n;
                chk(w.h ? "rx_hdr" : "rx_body", {rx_out_ctrl, rx_out_data}, {w.c, w.d});
            end
        end
        if (tx_out_wr) begin
            if (tx_exp.size() == 0) begin
                checks++;
                $display("FAIL tx_extra_word: got %h expected no word", {tx_out_ctrl, tx_out_data});
            end else begin
                w = tx_exp.pop_front();
                tx_out_cyc = cyc_n;
                chk("tx_word", {tx_out_ctrl, tx_out_data}, {w.c, w.d});
            end
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((rx_src.size() + rx_exp.size() + tx_src.size() + tx_exp.size()) != 0 && k < budget) begin
            cyc();
            k++;
        end
        checks++;
        if ((rx_src.size() + rx_exp.size() + tx_src.size() + tx_exp.size()) == 0) passed++;
        else $display("FAIL drain_timeout: got %0d words pending expected 0", rx_src.size() + rx_exp.size() + tx_src.size() + tx_exp.size());
    endtask

    task automatic send_rx(input int budget);
        int k = 0;
        while (rx_src.size() != 0 && k < budget) begin
            cyc();
            k++;
        end
        cyc();
        chk("rx_send_done", 72'(rx_src.size()), 72'd0);
    endtask

    task automatic add_rx(input int n, input logic [7:0] lastc, input logic [63:0] hdr, input bit keep);
        wd_t w;
        if (keep) begin
            w.h = 1'b1; w.c = 8'hff; w.d = hdr;
            rx_exp.push_back(w);
            outstanding += n;
            exp_pkt++;
        end else begin
            exp_drop++;
        end
        for (int i = 0; i < n; i++) begin
            w.h = 1'b0;
            w.d = {$urandom, $urandom};
            w.c = (i == n - 1) ? lastc : 8'h00;
            rx_src.push_back(w);
            if (keep) rx_exp.push_back(w);
        end
    endtask

    // Random frame of n words whose last word holds vb valid bytes; header from the length rules.
    task automatic add_rx_rand(input int n, input int vb);
        logic [15:0] bytes;
        bytes = 16'(8 * (n - 1) + vb);
        add_rx(n, 8'(1 << (8 - vb)), {16'(n), 16'd6, 16'd0, bytes}, 1'b1);
    endtask

    task automatic add_tx(input int nh, input int n);
        wd_t w;
        w.h = 1'b0;
        for (int i = 0; i < nh; i++) begin
            w.d = {$urandom, $urandom};
            w.c = (i == 0) ? 8'hff : (i == 1) ? 8'h40 : 8'(1 << $urandom_range(0, 7));
            tx_src.push_back(w);
        end
        for (int i = 0; i < n; i++) begin
            w.d = {$urandom, $urandom};
            w.c = (i == n - 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            tx_src.push_back(w);
            tx_exp.push_back(w);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int   g;
        tbl[0] = '{8,  8'h01, 64'h0008_0006_0000_0040};
        tbl[1] = '{8,  8'h08, 64'h0008_0006_0000_003d};
        tbl[2] = '{1,  8'h80, 64'h0001_0006_0000_0001};
        tbl[3] = '{2,  8'h01, 64'h0002_0006_0000_0010};
        tbl[4] = '{16, 8'h02, 64'h0010_0006_0000_007f};
        tbl[5] = '{3,  8'h40, 64'h0003_0006_0000_0012};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_rx_in_rdy", 72'(rx_in_rdy), 72'd0);
        chk("rst_tx_in_rdy", 72'(tx_in_rdy), 72'd0);
        chk("rst_rx_out_wr", 72'(rx_out_wr), 72'd0);
        chk("rst_tx_out_wr", 72'(tx_out_wr), 72'd0);
        chk("rst_rx_out", {rx_out_ctrl, rx_out_data}, 72'd0);
        chk("rst_tx_out", {tx_out_ctrl, tx_out_data}, 72'd0);
        chk("rst_pkt_cnt", 72'(rx_pkt_cnt), 72'd0);
        chk("rst_drop_cnt", 72'(rx_drop_cnt), 72'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        chk("post_rst_rx_in_rdy", 72'(rx_in_rdy), 72'd1);

        for (int i = 0; i < 6; i++) begin
            add_rx(tbl[i].n, tbl[i].lc, tbl[i].hdr, 1'b1);
            drain(200);
            chk("rx_hdr_latency", 72'(rx_hdr_cyc - rx_fin_cyc), 72'd2);
            chk("rx_body_span", 72'(rx_out_cyc - rx_hdr_cyc), 72'(tbl[i].n));
            chk("rx_pkt_cnt", 72'(rx_pkt_cnt), 72'(exp_pkt));
        end

        // Overflow: first frame parks in the buffer, second cannot fit and is dropped.
        rx_pct = 0;
        add_rx(10, 8'h01, 64'h000a_0006_0000_0050, 1'b1);
        add_rx(10, 8'h01, 64'h0, 1'b0);
        send_rx(200);
        chk("ovf_drop_cnt", 72'(rx_drop_cnt), 72'(exp_drop));
        chk("ovf_pkt_cnt", 72'(rx_pkt_cnt), 72'(exp_pkt - 1));
        rx_pct = 100;
        add_rx(5, 8'h04, 64'h0005_0006_0000_0026, 1'b1);
        drain(300);
        chk("ovf_after_pkt_cnt", 72'(rx_pkt_cnt), 72'(exp_pkt));

        // Length FIFO fills after four frames while the sink is stalled.
        rx_pct = 0;
        for (int i = 0; i < 4; i++) add_rx(2, 8'h01, 64'h0002_0006_0000_0010, 1'b1);
        send_rx(200);
        chk("lenfull_rx_in_rdy", 72'(rx_in_rdy), 72'd0);
        add_rx(2, 8'h80, 64'h0002_0006_0000_0009, 1'b1);
        repeat (3) cyc();
        chk("lenfull_held", 72'(rx_src.size()), 72'd2);
        rx_pct = 100;
        drain(300);
        chk("lenfull_pkt_cnt", 72'(rx_pkt_cnt), 72'(exp_pkt));

        // Tx: two header words then an 8-word frame, first at full rate then with gaps.
        add_tx(2, 8);
        drain(200);
        chk("tx_latency", 72'(tx_out_cyc - tx_in_cyc), 72'd1);
        tx_pct = 50;
        add_tx(2, 8);
        drain(400);
        add_tx(0, 3);
        add_tx(3, 2);
        drain(400);

        // Random mixed traffic, rx paced so the buffer never overflows.
        rx_pct = 70;
        tx_pct = 70;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                int n;
                n = $urandom_range(1, 6);
                g = 0;
                while (outstanding + n > 16 && g < 500) begin
                    cyc();
                    g++;
                end
                add_rx_rand(n, $urandom_range(1, 8));
            end else begin
                add_tx($urandom_range(0, 2), $urandom_range(2, 6));
            end
            if ($urandom_range(0, 2) == 0) cyc();
        end
        drain(3000);
        chk("rand_pkt_cnt", 72'(rx_pkt_cnt), 72'(exp_pkt));
        chk("rand_drop_cnt", 72'(rx_drop_cnt), 72'(exp_drop));

        // Reset in the middle of an rx body.
        rx_pct = 100;
        tx_pct = 100;
        add_rx(8, 8'h01, 64'h0008_0006_0000_0040, 1'b1);
        g = 0;
        while (rx_exp.size() > 4 && g < 100) begin
            cyc();
            g++;
        end
        chk("midbody_reached", 72'(rx_exp.size()), 72'd4);
        @(negedge clk);
        rx_in_wr = 1'b0;
        tx_in_wr = 1'b0;
        rx_out_rdy = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_rx_out_wr", 72'(rx_out_wr), 72'd0);
        chk("mrst_rx_out", {rx_out_ctrl, rx_out_data}, 72'd0);
        chk("mrst_rx_in_rdy", 72'(rx_in_rdy), 72'd0);
        chk("mrst_pkt_cnt", 72'(rx_pkt_cnt), 72'd0);
        rx_src.delete();
        rx_exp.delete();
        outstanding = 0;
        exp_pkt = 0;
        exp_drop = 0;
        @(negedge clk);
        reset = 1'b1;
        add_rx(3, 8'h10, 64'h0003_0006_0000_0014, 1'b1);
        drain(200);
        chk("mrst_after_pkt_cnt", 72'(rx_pkt_cnt), 72'(exp_pkt));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/add_rm_hdr_sf.md
# add_rm_hdr_sf

Parametrised store-and-forward successor to the MAC-side header shim. Receive direction: buffers each Ethernet frame, measures it, and prepends an IOQ module header carrying word length, source port and byte length. Transmit direction: strips every leading module-header word before the MAC. Adds overflow drop with pointer rewind and packet/drop statistics.

## Interface
- DATA_WIDTH, 64, datapath width in bits (multiple of 8, 32..256)
- CTRL_WIDTH, DATA_WIDTH/8, one ctrl bit per data byte
- IOQ_STAGE_NUM, 'hff, ctrl value marking the generated header word
- PORT_NUMBER, 0, MAC index; header source port = 2*PORT_NUMBER
- BUF_ADDR_BITS, 9, data buffer depth = 2^BUF_ADDR_BITS words
- LEN_FIFO_BITS, 2, length FIFO depth = 2^LEN_FIFO_BITS packets
- clk  in  1  sole clock, all logic rising-edge
- reset  in  1  asynchronous, active-low; asserted low clears all state
- rx_in_data/rx_in_ctrl/rx_in_wr  in  DATA_WIDTH/CTRL_WIDTH/1  raw frame from MAC
- rx_in_rdy  out  1  block accepts an rx word this cycle
- rx_out_data/rx_out_ctrl/rx_out_wr  out  DATA_WIDTH/CTRL_WIDTH/1  header+frame to pipeline
- rx_out_rdy  in  1  downstream can accept
- tx_in_data/tx_in_ctrl/tx_in_wr  in  DATA_WIDTH/CTRL_WIDTH/1  headered packet from output queues
- tx_in_rdy  out  1  block accepts a tx word
- tx_out_data/tx_out_ctrl/tx_out_wr  out  DATA_WIDTH/CTRL_WIDTH/1  frame to MAC
- tx_out_rdy  in  1  MAC can accept
- rx_pkt_cnt  out  32  frames forwarded with header (wraps)
- rx_drop_cnt  out  32  frames dropped on overflow (wraps)

## Operation
- Handshake on all ports: a word transfers when *_wr is high; *_wr may be driven high only in a cycle where the matching *_rdy is high.
- Frame format: ctrl==0 on non-final words; final word ctrl is one-hot, bit k set means CTRL_WIDTH-k valid bytes (bit CTRL_WIDTH-1 = 1 byte, bit 0 = all bytes).
- Rx write side: each accepted word written at wr_ptr; word counter and byte counter (16 bits each, saturating at 'hffff) accumulate. On final word, length entry {word_cnt, byte_cnt} pushed to length FIFO and committed pointer = wr_ptr+1.
- Overflow: if buffer full when a word arrives, enter DROP: discard words up to and including the final word, then rewind wr_ptr to committed pointer, increment rx_drop_cnt, no length entry. rx_in_rdy stays high in DROP.
- rx_in_rdy = reset deasserted AND length FIFO not full.
- Rx read FSM: IDLE -> HDR when length FIFO non-empty; HDR emits one word ctrl=IOQ_STAGE_NUM, data[63:48]=word_cnt, [47:32]=2*PORT_NUMBER, [31:16]=0, [15:0]=byte_cnt (upper bits zero when DATA_WIDTH>64); -> BODY streams word_cnt words from rd_ptr with stored ctrl; after last word pop length FIFO, increment rx_pkt_cnt, -> IDLE. Stalls in any state while rx_out_rdy low.
- Pointers wrap modulo 2^BUF_ADDR_BITS; full/empty use one extra MSB.
- Tx FSM: SKIP discards every word with ctrl!=0 while in SKIP; first ctrl==0 word -> PASS and is forwarded; PASS forwards words until one with ctrl!=0 (final word, forwarded) -> SKIP. Single-register output stage; tx_in_rdy = tx_out_rdy OR output register empty.
- Simultaneous rx write of final word and read of last body word: both proceed; length FIFO push and pop same cycle keep occupancy.

## Timing
- Reset values: all *_wr 0, all data/ctrl outputs 0, counters 0, rx_in_rdy 0, tx_in_rdy 0, FSMs IDLE/SKIP, pointers 0.
- Rx: header word on rx_out 2 cycles after final input word accepted (length FIFO push, then registered header) with rx_out_rdy high; body follows back-to-back, one word per cycle.
- Tx: latency 1 cycle, full throughput.
- Reset asserted mid-packet: packet lost, no counter change, outputs cleared immediately.

## Test plan
- 64-byte frame (8 words, last ctrl=8'h01) -> header ctrl=8'hff data=64'h0008_0000_0000_0040 (PORT_NUMBER 0), then 8 words identical, rx_pkt_cnt=1.
- 61-byte frame, last ctrl=8'h08, PORT_NUMBER=3 -> header data=64'h0008_0006_0000_003d.
- BUF_ADDR_BITS=4, rx_out_rdy held low, two 10-word frames -> first forwarded later, second dropped, rx_drop_cnt=1, wr_ptr rewound to 10.
- Four frames with rx_out_rdy low, LEN_FIFO_BITS=2 -> rx_in_rdy drops after 4th final word; releases after first frame drains.
- Tx: 2 header words (ctrl 8'hff, 8'h40) + 8-word frame -> exactly 8 words on tx_out, random tx_out_rdy gaps lose nothing.
- Reset low during rx BODY -> all outputs 0 same cycle; next frame forwarded correctly.
